// File: rtl/hs_unit_pkg.sv
// Shared constants and helpers for the hs_unit elastic pipeline blocks.
package hs_unit_pkg;

    localparam int HS_UNIT_PIPE_MAX_DEPTH = 16;

    // Beats a pipe of the given depth can hold: main + skid per stage.
    function automatic int hs_unit_pipe_capacity(input int depth);
        return 2 * depth;
    endfunction

endpackage

// File: rtl/hs_unit_regslice.sv
// One full-throughput skid-buffer stage with registered valid and ready.
// Optional synchronous flush when HS_UNIT_PIPE_FLUSH_EN is defined.
module hs_unit_regslice
    import hs_unit_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0
) (
    input  logic     clk,
    input  logic     aresetn,
`ifdef HS_UNIT_PIPE_FLUSH_EN
    input  logic     flush,
`endif
    input  logic     in_valid,
    output logic     in_ready,
    input  DATA_TYPE in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output DATA_TYPE out_data
);

    logic     mv, kv;
    DATA_TYPE md, kd;
    logic     flush_i;
    logic     acc, emit, main_free;

`ifdef HS_UNIT_PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Flush gates both handshakes so no beat moves on the clearing edge.
    assign in_ready  = !kv && !flush_i;
    assign out_valid = mv && !flush_i;
    assign out_data  = md;

    assign acc       = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign main_free = !mv || emit;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mv <= 1'b0;
            kv <= 1'b0;
        end else if (flush_i) begin
            mv <= 1'b0;
            kv <= 1'b0;
        end else if (main_free) begin
            if (kv) begin
                mv <= 1'b1;
                kv <= 1'b0;
            end else begin
                mv <= acc;
            end
        end else if (acc) begin
            kv <= 1'b1;
        end
    end

    // Payload only moves on accept/shift, so idle cycles never disturb it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            md <= RESET_VALUE;
            kd <= RESET_VALUE;
        end else if (!flush_i) begin
            if (main_free) begin
                if (kv)       md <= kd;
                else if (acc) md <= in_data;
            end else if (acc) begin
                kd <= in_data;
            end
        end
    end

endmodule

// File: rtl/hs_unit_pipe.sv
// Elastic pipeline register: DEPTH cascaded hs_unit_regslice stages.
// Define HS_UNIT_PIPE_FLUSH_EN to add the synchronous flush port.
module hs_unit_pipe
    import hs_unit_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter int       DEPTH       = 1
) (
    input  logic     clk,
    input  logic     aresetn,
`ifdef HS_UNIT_PIPE_FLUSH_EN
    input  logic     flush,
`endif
    input  logic     s_valid,
    output logic     s_ready,
    input  DATA_TYPE s_data,
    output logic     m_valid,
    input  logic     m_ready,
    output DATA_TYPE m_data
);

    if (DEPTH < 1 || DEPTH > HS_UNIT_PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("hs_unit_pipe: DEPTH=%0d outside 1..%0d", DEPTH, HS_UNIT_PIPE_MAX_DEPTH);
    end

    // Link k sits between stage k-1 and stage k; link 0 is the upstream port.
    logic [DEPTH:0] vld, rdy;
    DATA_TYPE       dat [0:DEPTH];

    assign vld[0]     = s_valid;
    assign dat[0]     = s_data;
    assign s_ready    = rdy[0];
    assign m_valid    = vld[DEPTH];
    assign m_data     = dat[DEPTH];
    assign rdy[DEPTH] = m_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        hs_unit_regslice #(
            .DATA_TYPE  (DATA_TYPE),
            .RESET_VALUE(RESET_VALUE)
        ) u_slice (
            .clk      (clk),
            .aresetn  (aresetn),
`ifdef HS_UNIT_PIPE_FLUSH_EN
            .flush    (flush),
`endif
            .in_valid (vld[i]),
            .in_ready (rdy[i]),
            .in_data  (dat[i]),
            .out_valid(vld[i+1]),
            .out_ready(rdy[i+1]),
            .out_data (dat[i+1])
        );
    end

endmodule

// File: tb/tb_hs_unit_pipe.sv
// Directed bench for hs_unit_pipe: five depths share one stimulus, each with its own scoreboard.
// Flush steps run only when HS_UNIT_PIPE_FLUSH_EN is defined.
module tb_hs_unit_pipe;

    localparam int N = 5;
    localparam logic [7:0] RV = 8'hA5;

    function automatic int dep(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            default: return 16;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       aresetn;
    logic       s_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       sr [N];
    logic       mv [N];
    logic [7:0] md [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        hs_unit_pipe #(
            .DATA_TYPE  (logic [7:0]),
            .RESET_VALUE(RV),
            .DEPTH      (dep(g))
        ) u_dut (
            .clk    (clk),
            .aresetn(aresetn),
`ifdef HS_UNIT_PIPE_FLUSH_EN
            .flush  (flush),
`endif
            .s_valid(s_valid),
            .s_ready(sr[g]),
            .s_data (s_data),
            .m_valid(mv[g]),
            .m_ready(m_ready),
            .m_data (md[g])
        );
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] mem [N][64];
    int         wp [N];
    int         rp [N];
    logic       st [N];
    logic [7:0] pd [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_clear();
        for (int i = 0; i < N; i++) rp[i] = wp[i];
    endtask

    // Record handshakes from pre-edge values, advance one edge, then check invariants.
    task automatic tick();
        for (int i = 0; i < N; i++) begin
            if (mv[i] && m_ready && !flush) begin
                chk($sformatf("nonempty_d%0d", dep(i)), 32'(wp[i] > rp[i]), 32'd1);
                chk($sformatf("data_d%0d", dep(i)), 32'(md[i]), 32'(mem[i][rp[i] % 64]));
                rp[i]++;
            end
            if (s_valid && sr[i] && !flush) begin
                mem[i][wp[i] % 64] = s_data;
                wp[i]++;
            end
            st[i] = mv[i] && !m_ready && !flush;
            pd[i] = md[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("occupancy_d%0d", dep(i)), 32'((wp[i] - rp[i]) <= 2 * dep(i)), 32'd1);
            if (st[i]) begin
                chk($sformatf("stall_valid_d%0d", dep(i)), 32'(mv[i]), 32'd1);
                chk($sformatf("stall_data_d%0d", dep(i)), 32'(md[i]), 32'(pd[i]));
            end
        end
    endtask

    // Push one beat into empty pipes; each must present it after exactly DEPTH edges.
    task automatic latency_check(input string tag, input logic [7:0] val);
        int lat [N];
        for (int i = 0; i < N; i++) lat[i] = -1;
        s_valid = 1'b1;
        s_data  = val;
        m_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            s_valid = 1'b0;
            for (int i = 0; i < N; i++)
                if (lat[i] < 0 && mv[i]) begin
                    lat[i] = c;
                    chk($sformatf("%s_data_d%0d", tag, dep(i)), 32'(md[i]), 32'(val));
                end
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_lat_d%0d", tag, dep(i)), 32'(lat[i]), 32'(dep(i)));
    endtask

    initial begin
        int first [N];
        int last  [N];
        int nv    [N];
        int srlow [N];
        int base  [N];

        for (int i = 0; i < N; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end

        // Reset state, checked while reset is still asserted
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_mvalid_d%0d", dep(i)), 32'(mv[i]), 32'd0);
            chk($sformatf("rst_sready_d%0d", dep(i)), 32'(sr[i]), 32'd1);
            chk($sformatf("rst_mdata_d%0d", dep(i)), 32'(md[i]), 32'(RV));
        end
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("idle_mvalid_d%0d", dep(i)), 32'(mv[i]), 32'd0);
            chk($sformatf("idle_mdata_d%0d", dep(i)), 32'(md[i]), 32'(RV));
        end

        // Streaming 0..99 back-to-back with m_ready held high
        for (int i = 0; i < N; i++) begin
            first[i] = -1; last[i] = -1; nv[i] = 0; srlow[i] = 0; base[i] = rp[i];
        end
        m_ready = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            s_valid = (c <= 100);
            s_data  = 8'(c - 1);
            for (int i = 0; i < N; i++) if (!sr[i]) srlow[i]++;
            tick();
            for (int i = 0; i < N; i++)
                if (mv[i]) begin
                    if (first[i] < 0) first[i] = c;
                    last[i] = c;
                    nv[i]++;
                end
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("stream_lat_d%0d", dep(i)), 32'(first[i]), 32'(dep(i)));
            chk($sformatf("stream_span_d%0d", dep(i)), 32'(last[i] - first[i]), 32'd99);
            chk($sformatf("stream_count_d%0d", dep(i)), 32'(nv[i]), 32'd100);
            chk($sformatf("stream_out_d%0d", dep(i)), 32'(rp[i] - base[i]), 32'd100);
            chk($sformatf("stream_sready_d%0d", dep(i)), 32'(srlow[i]), 32'd0);
        end
        chk("stream_last_data_d3", 32'(md[2]), 32'd99);

        // Full stall: capacity fills to 2*DEPTH then s_ready drops
        for (int i = 0; i < N; i++) base[i] = wp[i];
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            s_data = 8'(c);
            tick();
            if (c < 3) chk($sformatf("stall_sready_d2_e%0d", c + 1), 32'(sr[1]), 32'd1);
            if (c == 3) chk("stall_sready_d2_full", 32'(sr[1]), 32'd0);
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("stall_accepted_d%0d", dep(i)), 32'(wp[i] - base[i]), 32'(2 * dep(i)));
            chk($sformatf("stall_sready_d%0d", dep(i)), 32'(sr[i]), 32'd0);
            chk($sformatf("stall_head_d%0d", dep(i)), 32'(md[i]), 32'd0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) base[i] = rp[i];
        repeat (40) tick();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("stall_drained_d%0d", dep(i)), 32'(rp[i] - base[i]), 32'(2 * dep(i)));
            chk($sformatf("stall_tail_d%0d", dep(i)), 32'(md[i]), 32'(2 * dep(i) - 1));
        end

        // Random traffic; scoreboard plus stall-stability in tick()
        for (int c = 0; c < 3000; c++) begin
            s_valid = 1'($urandom_range(1));
            m_ready = 1'($urandom_range(1));
            s_data  = 8'($urandom_range(255));
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (40) tick();
        for (int i = 0; i < N; i++)
            chk($sformatf("rand_drained_d%0d", dep(i)), 32'(wp[i] - rp[i]), 32'd0);

        // Mid-stream reset with beats in flight
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            s_data = 8'(8'h70 + c);
            tick();
        end
        s_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("mrst_mvalid_d%0d", dep(i)), 32'(mv[i]), 32'd0);
            chk($sformatf("mrst_sready_d%0d", dep(i)), 32'(sr[i]), 32'd1);
            chk($sformatf("mrst_mdata_d%0d", dep(i)), 32'(md[i]), 32'(RV));
        end
        sb_clear();
        @(posedge clk);
        #1 aresetn = 1'b1;
        latency_check("mrst", 8'h3C);

`ifdef HS_UNIT_PIPE_FLUSH_EN
        // Flush a full pipe; gating is combinational, data regs are retained
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            s_data = 8'(8'h40 + c);
            tick();
        end
        s_valid = 1'b0;
        flush   = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("flush_sready_d%0d", dep(i)), 32'(sr[i]), 32'd0);
            chk($sformatf("flush_mvalid_d%0d", dep(i)), 32'(mv[i]), 32'd0);
        end
        tick();
        flush = 1'b0;
        sb_clear();
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("postflush_mvalid_d%0d", dep(i)), 32'(mv[i]), 32'd0);
            chk($sformatf("postflush_sready_d%0d", dep(i)), 32'(sr[i]), 32'd1);
            chk($sformatf("postflush_mdata_d%0d", dep(i)), 32'(md[i]), 32'h40);
        end
        latency_check("flushA", 8'hAA);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
